// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller:
// FSM state encoding and default multi-cycle latency.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MC_ISSUE = 2'd2
  } state_t;

  // Default number of stall cycles before a mult/div issues.
  localparam int MC_LAT_DEFAULT = 4;

  // The multi-cycle countdown must hold MC_LAT-1 for MC_LAT up to 15.
  localparam int MC_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the ID-stage hazard sources and the pipeline
// register enables driven by pipe_hazard_ctrl.
//
// Timing contract: there is no valid/ready pair on this bundle. Every
// input is a level sampled by the controller at posedge clk. Every output
// is a combinational level that settles before the negedge, where the
// PC, IF/ID and ID/EX registers sample it. The controller never applies
// back-pressure except through pc_write/if_id_write.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import pipe_ctrl_pkg::*;

  // ID / EX hazard sources
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             id_branch_taken;
  logic             id_mc_op;

  // Pipeline register controls
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_count;

  // Current FSM state, for observation only
  state_t           dbg_state;

  // Pipeline side: drives the hazard sources, receives the controls.
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, id_mc_op,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy,
           stall_count, dbg_state
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
           id_branch_taken, id_mc_op,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, mc_busy,
           stall_count, dbg_state
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use hazard detector: the load in EX writes a register that the
// instruction in ID reads. Register $zero is never a real dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  output logic       load_use_o
);

  // Match the load destination against the live source operands of ID.
  always_comb begin
    load_use_o = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                 ((ex_rt_i == id_rs_i) || (id_uses_rt_i && (ex_rt_i == id_rt_i)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core. Decides each
// cycle whether PC and IF/ID advance, whether IF/ID is flushed and whether
// a bubble is injected into ID/EX. Priority: load-use > multi-cycle > branch.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   bus
);

  state_t              state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic pc_write;
  logic if_id_write;
  logic if_id_flush;
  logic id_ex_bubble;
  logic mc_busy;

  load_use_detect u_load_use (
    .id_rs_i       (bus.id_rs),
    .id_rt_i       (bus.id_rt),
    .id_uses_rt_i  (bus.id_uses_rt),
    .ex_mem_read_i (bus.ex_mem_read),
    .ex_rt_i       (bus.ex_rt),
    .load_use_o    (load_use)
  );

  // State, countdown and stall counter registers; async clear on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      mc_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mc_cnt_q    <= mc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and output decode. Defaults are the stall/reset values, so
  // while rst is low the outputs sit at their reset levels combinationally.
  always_comb begin
    state_d      = state_q;
    mc_cnt_d     = mc_cnt_q;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b1;
    mc_busy      = 1'b0;

    if (rst) begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            state_d = RUN;
          end else if (bus.id_mc_op) begin
            // The detection cycle itself is the first of MC_LAT stalls.
            mc_cnt_d = MC_CNT_W'(MC_LAT - 1);
            state_d  = (MC_LAT == 1) ? MC_ISSUE : MC_WAIT;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = bus.id_branch_taken;
            id_ex_bubble = 1'b0;
          end
        end
        MC_WAIT: begin
          // Inputs are ignored: any load in EX has drained by now.
          mc_busy  = 1'b1;
          mc_cnt_d = mc_cnt_q - 1'b1;
          if (mc_cnt_q == MC_CNT_W'(1)) begin
            state_d = MC_ISSUE;
          end
        end
        MC_ISSUE: begin
          // id_mc_op is ignored here so the held op does not re-trigger.
          if (load_use) begin
            state_d = MC_ISSUE;
          end else begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            if_id_flush  = bus.id_branch_taken;
            id_ex_bubble = 1'b0;
            state_d      = RUN;
          end
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.pc_write     = pc_write;
    bus.if_id_write  = if_id_write;
    bus.if_id_flush  = if_id_flush;
    bus.id_ex_bubble = id_ex_bubble;
    bus.mc_busy      = mc_busy;
    bus.stall_count  = stall_cnt_q;
    bus.dbg_state    = state_q;
  end

endmodule
